// File: rtl/dual_edge_alu_pkg.sv
// Shared types and constants for the dual-edge add/sub scheduler.
package dual_edge_alu_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ST_W    = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    typedef logic req_id_t;

    // Requester 0 wins the first contested arbitration after reset.
    localparam req_id_t RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/dual_edge_addsub_dp.sv
// Dual-edge datapath: c = a + b on the falling edge, f = c - d on the rising edge.
module dual_edge_addsub_dp
    import dual_edge_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] f,
    output logic             borrow,
    output logic             carry_out
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] c_q, c_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             borrow_q, borrow_d;
    logic             carry_out_q, carry_out_d;

    // Falling-edge adder stage next value.
    always_comb begin
        c_d     = c_q;
        carry_d = carry_q;
        if (add_en) begin
            {carry_d, c_d} = SUM_W'(a) + SUM_W'(b);
        end
    end

    // Falling-edge sum/carry register; only half a cycle to the next stage.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            carry_q <= carry_d;
        end
    end

    // Rising-edge subtract stage next value; holds when not loading.
    always_comb begin
        f_d         = f_q;
        borrow_d    = borrow_q;
        carry_out_d = carry_out_q;
        if (load_en) begin
            f_d         = c_q - d;
            borrow_d    = (d > c_q);
            carry_out_d = carry_q;
        end
    end

    // Rising-edge result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= '0;
            borrow_q    <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            borrow_q    <= borrow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign f         = f_q;
    assign borrow    = borrow_q;
    assign carry_out = carry_out_q;

endmodule

// File: rtl/dual_edge_alu_sched.sv
// Round-robin front end sharing one dual-edge add/sub datapath between two requesters.
module dual_edge_alu_sched
    import dual_edge_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_d,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_borrow
);

    state_t           state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    req_id_t          id_q, id_d;
    req_id_t          rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [NUM_REQ-1:0] valid_c, grant_c;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        valid_c = {req1_valid, req0_valid};
        grant_c = valid_c;
        if (valid_c == 2'b11) begin
            grant_c = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && grant_c[0];
    assign req1_ready = (state_q == ST_IDLE) && grant_c[1];

    // FSM next state, operand capture and response flags.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        a_d          = a_q;
        b_d          = b_q;
        d_d          = d_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant_c) begin
                    state_d      = ST_EXEC;
                    id_d         = grant_c[1];
                    last_grant_d = grant_c[1];
                    a_d          = grant_c[1] ? req1_a : req0_a;
                    b_d          = grant_c[1] ? req1_b : req0_b;
                    d_d          = grant_c[1] ? req1_d : req0_d;
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= RESET_LAST_GRANT;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            d_q          <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            d_q          <= d_d;
        end
    end

    dual_edge_addsub_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_en    (state_q == ST_EXEC),
        .a         (a_q),
        .b         (b_q),
        .load_en   (state_q == ST_EXEC),
        .d         (d_q),
        .f         (rsp_data),
        .borrow    (rsp_borrow),
        .carry_out (rsp_carry)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_dual_edge_alu_sched.sv
// Directed scoreboard bench for dual_edge_alu_sched (WIDTH = 8).
module tb_dual_edge_alu_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req0_d, req1_a, req1_b, req1_d;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_borrow;
    logic [7:0] rsp_data;

    always #5 clk = ~clk;

    dual_edge_alu_sched #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_d     (req0_d),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_d     (req1_d),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_borrow (rsp_borrow)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
    } ops_t;

    typedef struct packed {
        logic        id;
        logic [7:0]  data;
        logic        carry;
        logic        borrow;
        logic [31:0] acc_cyc;
    } exp_t;

    ops_t q0[$];
    ops_t q1[$];
    exp_t sb[$];
    logic grant_log[$];
    int   acc_log[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   retire_cyc = 0;
    int   last_acc = 0;
    logic model_last = 1'b1;
    logic prev_rsp_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        if (q0.size() > 0) {req0_a, req0_b, req0_d} = q0[0];
        if (q1.size() > 0) {req1_a, req1_b, req1_d} = q1[0];
    endtask

    // One clock: sample and score at the falling edge, then update stimulus after the rising edge.
    task automatic cycle();
        logic       hs0, hs1, exp_id;
        logic [8:0] sum;
        ops_t       op;
        exp_t       e;
        @(negedge clk);
        cyc++;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (req0_ready || req1_ready) chk("single_ready", 32'(req0_ready && req1_ready), 0);
        if (sb.size() == 0) begin
            chk("rsp_spurious", 32'(rsp_valid), 0);
        end else if (rsp_valid) begin
            chk("ready_while_rsp", 32'({req1_ready, req0_ready}), 0);
            chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
            chk("rsp_carry", 32'(rsp_carry), 32'(sb[0].carry));
            chk("rsp_borrow", 32'(rsp_borrow), 32'(sb[0].borrow));
            if (!prev_rsp_valid) chk("latency", 32'(cyc) - sb[0].acc_cyc, 2);
            if (rsp_ready) begin
                void'(sb.pop_front());
                retire_cyc = cyc;
            end
        end
        prev_rsp_valid = rsp_valid;
        if (hs0 || hs1) begin
            exp_id = (req0_valid && req1_valid) ? ~model_last : req1_valid;
            chk("grant_id", 32'(hs1), 32'(exp_id));
            model_last = hs1;
            op = hs1 ? q1.pop_front() : q0.pop_front();
            sum = 9'(op.a) + 9'(op.b);
            e.id      = hs1;
            e.data    = sum[7:0] - op.d;
            e.carry   = sum[8];
            e.borrow  = (op.d > sum[7:0]);
            e.acc_cyc = 32'(cyc);
            sb.push_back(e);
            grant_log.push_back(hs1);
            acc_log.push_back(cyc);
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_done(input int max);
        int n = 0;
        while ((q0.size() + q1.size() + sb.size()) > 0 && n < max) begin
            cycle();
            n++;
        end
        if (n >= max) chk("timeout", 32'(q0.size() + q1.size() + sb.size()), 0);
    endtask

    task automatic reset_dut(input int n);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        drive();
        model_last = 1'b1;
        prev_rsp_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_order[4];
        int   n;
        int   start;
        exp_order[0] = 1'b0;
        exp_order[1] = 1'b1;
        exp_order[2] = 1'b0;
        exp_order[3] = 1'b1;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive();
        req0_a = '0; req0_b = '0; req0_d = '0;
        req1_a = '0; req1_b = '0; req1_d = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values.
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_carry", 32'(rsp_carry), 0);
        chk("reset_rsp_borrow", 32'(rsp_borrow), 0);
        chk("reset_readies", 32'({req1_ready, req0_ready}), 0);
        rst_n = 1'b1;

        // Single request from requester 0.
        q0.push_back('{a: 8'd3, b: 8'd4, d: 8'd2});
        drive();
        run_until_done(50);

        // Wrap-around with carry and borrow from requester 1.
        q1.push_back('{a: 8'd200, b: 8'd100, d: 8'd50});
        drive();
        run_until_done(50);

        // Fairness from reset with both requesters always valid.
        reset_dut(2);
        q0.push_back('{a: 8'd1, b: 8'd2, d: 8'd3});
        q0.push_back('{a: 8'd4, b: 8'd5, d: 8'd6});
        q1.push_back('{a: 8'd7, b: 8'd8, d: 8'd9});
        q1.push_back('{a: 8'd10, b: 8'd11, d: 8'd12});
        grant_log.delete();
        drive();
        run_until_done(100);
        chk("fair_count", 32'(grant_log.size()), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("fair_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // Backpressure: response held while a new request waits.
        rsp_ready = 1'b0;
        q0.push_back('{a: 8'd50, b: 8'd60, d: 8'd70});
        drive();
        n = 0;
        while (!prev_rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_rsp_seen", 32'(prev_rsp_valid), 1);
        q1.push_back('{a: 8'd9, b: 8'd9, d: 8'd9});
        drive();
        repeat (5) cycle();
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("accept_after_retire", 32'(last_acc - retire_cyc), 1);
        run_until_done(50);

        // Reset between the accepting rising edge and the next falling edge.
        q0.push_back('{a: 8'd10, b: 8'd20, d: 8'd5});
        drive();
        start = acc_log.size();
        n = 0;
        while (acc_log.size() == start && n < 20) begin
            cycle();
            n++;
        end
        chk("exec_accept_seen", 32'(acc_log.size() - start), 1);
        reset_dut(2);
        repeat (3) cycle();
        q0.push_back('{a: 8'd1, b: 8'd1, d: 8'd1});
        q1.push_back('{a: 8'd2, b: 8'd2, d: 8'd2});
        grant_log.delete();
        drive();
        run_until_done(50);
        if (grant_log.size() > 0) chk("post_reset_first_grant", 32'(grant_log[0]), 0);
        else chk("post_reset_grants", 32'(grant_log.size()), 2);

        // Back-to-back: next request waits one cycle after retirement.
        acc_log.delete();
        q0.push_back('{a: 8'd100, b: 8'd27, d: 8'd7});
        q0.push_back('{a: 8'd255, b: 8'd255, d: 8'd0});
        drive();
        run_until_done(50);
        if (acc_log.size() == 2) chk("issue_interval", 32'(acc_log[1] - acc_log[0]), 3);
        else chk("b2b_accepts", 32'(acc_log.size()), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
